// File: rtl/tt_accum_pkg.sv
// Shared constants for the parametrised accumulator tile: mode encoding,
// uio bit positions and the fixed bidirectional-pad direction mask.
package tt_accum_pkg;

   typedef enum logic [1:0] {
      MODE_LOAD_SUM  = 2'd0,
      MODE_LOAD_DIFF = 2'd1,
      MODE_ACC_ADD   = 2'd2,
      MODE_ACC_SUB   = 2'd3
   } mode_t;

   // uio_in control bits
   localparam int STROBE  = 0;
   localparam int CLEAR   = 1;
   localparam int MODE_LO = 2;

   // uio_out status bits
   localparam int OVF     = 4;
   localparam int VALID   = 5;
   localparam int CNT_LO  = 6;

   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_in_sync.sv
// Pad-input registers plus a rising-edge detector on the registered strobe.
// Every downstream decision uses only these registered copies.
module tt_in_sync
   import tt_accum_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] s_ui,
   output logic [7:0] s_uio,
   output logic       strobe_rise
);

   logic s_strobe_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ui       <= '0;
         s_uio      <= '0;
         s_strobe_d <= 1'b0;
      end else begin
         s_ui       <= ui_in;
         s_uio      <= uio_in;
         s_strobe_d <= s_uio[STROBE];
      end
   end

   // Tracks regardless of ena, so a strobe already high when ena rises is not an edge.
   assign strobe_rise = s_uio[STROBE] & ~s_strobe_d;

endmodule

// File: rtl/tt_um_param_accum.sv
// TinyTapeout add/subtract/accumulate tile: registered pad inputs, strobe-edge
// triggered arithmetic into a saturating or wrapping accumulator with status.
module tt_um_param_accum
   import tt_accum_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int ACCW = 8,
   parameter int SAT  = 1
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam int RW = ACCW + 1;

   logic [7:0]      s_ui;
   logic [7:0]      s_uio;
   logic            strobe_rise;
   logic [ACCW-1:0] acc;
   logic            ovf;
   logic [1:0]      cnt;
   logic            valid;

   logic            fire;
   logic            do_clear;
   logic            sub_op;
   logic            out_of_range;
   logic [RW-1:0]   a_ext;
   logic [RW-1:0]   b_ext;
   logic [RW-1:0]   raw;
   logic [ACCW-1:0] acc_next;
   logic            unused_ok;

   tt_in_sync u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .ui_in       (ui_in),
      .uio_in      (uio_in),
      .s_ui        (s_ui),
      .s_uio       (s_uio),
      .strobe_rise (strobe_rise)
   );

   assign unused_ok = ^{s_ui, s_uio};
   assign uio_oe    = UIO_OE_MASK;

   always_comb begin
      fire     = ena & strobe_rise;
      do_clear = ena & s_uio[CLEAR];
      a_ext    = RW'(s_ui[OPW-1:0]);
      b_ext    = RW'(s_ui[4 +: OPW]);
      sub_op   = 1'b0;
      raw      = '0;
      unique case (mode_t'(s_uio[MODE_LO +: 2]))
         MODE_LOAD_SUM:  raw = a_ext + b_ext;
         MODE_LOAD_DIFF: begin raw = a_ext - b_ext; sub_op = 1'b1; end
         MODE_ACC_ADD:   raw = RW'(acc) + a_ext + b_ext;
         MODE_ACC_SUB:   begin raw = RW'(acc) - (a_ext + b_ext); sub_op = 1'b1; end
         default:        raw = '0;
      endcase
      // Operand magnitudes are below 2^ACCW, so the extra bit is a carry for
      // additions and a borrow for subtractions.
      out_of_range = raw[ACCW];
      acc_next     = raw[ACCW-1:0];
      if (out_of_range && SAT != 0) begin
         acc_next = sub_op ? '0 : '1;
      end
      uo_out               = '0;
      uo_out[ACCW-1:0]     = acc;
      uio_out              = '0;
      uio_out[OVF]         = ovf;
      uio_out[VALID]       = valid;
      uio_out[CNT_LO +: 2] = cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         // Clear wins; a coincident strobe edge is dropped.
         if (do_clear) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
         end else if (fire) begin
            acc   <= acc_next;
            ovf   <= ovf | out_of_range;
            cnt   <= cnt + 2'd1;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/tt_um_param_accum.md
# tt_um_param_accum

Parametrised successor to the nibble-adder tile: a TinyTapeout user module that registers its pad inputs, detects a strobe edge, and performs one of four add/subtract/accumulate operations on two OPW-bit operands taken from `ui_in`. The result lands in an ACCW-bit accumulator with selectable saturate or wrap behaviour, a sticky overflow flag and an operation counter. It sits directly behind the TinyTapeout pad ring, with no other on-chip logic.

## Interface
- OPW, 4: operand width.
  - Range 2..4.
  - A = `ui_in[OPW-1:0]`, B = `ui_in[4+OPW-1:4]`.
  - Unused operand bits are ignored.
- ACCW, 8: accumulator width.
  - Range OPW+1..8.
  - Zero-extended onto `uo_out`.
- SAT, 1: 1 = saturate at 0 / 2^ACCW-1; 0 = wrap mod 2^ACCW.
- clk: input, 1. Clock.
- rst_n: input, 1. Reset, asynchronous, active-low.
- ena: input, 1. Operations fire only while high.
- ui_in: input, 8. Operands A and B.
- uio_in: input, 8. Control inputs:
  - [0] strobe.
  - [1] clear.
  - [3:2] mode.
  - [7:4] ignored.
- uo_out: output, 8. Accumulator value, zero-extended.
- uio_out: output, 8. Status outputs:
  - [3:0] = 0.
  - [4] ovf (sticky).
  - [5] valid (1-cycle pulse).
  - [7:6] op count.
- uio_oe: output, 8. Constant 8'hF0, independent of ena and reset.

## Operation
- **Input register.** `ui_in` and `uio_in` are registered every clk, regardless of ena. All decoding uses the registered copies (s_*). A second register on s_strobe gives s_strobe_d.
- **Fire condition.** fire = ena & s_strobe & ~s_strobe_d. Operands and mode are taken from the same registered sample as the strobe edge.
- **Mode encoding.** All arithmetic is done at ACCW+1 bits, with A and B zero-extended.
  - 0 LOAD_SUM: acc = A+B.
  - 1 LOAD_DIFF: acc = A-B.
  - 2 ACC_ADD: acc = acc+A+B.
  - 3 ACC_SUB: acc = acc-(A+B).
- **Overflow.** Overflow means the true result is above 2^ACCW-1; underflow means it is below 0.
  - SAT=1: the result clamps to 2^ACCW-1 or 0 respectively.
  - SAT=0: the low ACCW bits are kept.
  - Either way, ovf is set and stays set until clear or reset.
- **On fire.**
  - acc is updated.
  - count increments mod 4.
  - valid pulses high for exactly one cycle.
- **Clear.** When ena & s_clear:
  - acc, ovf and count go to 0.
  - valid stays 0.
  - Clear has priority over a simultaneous fire. That strobe edge is dropped, not deferred.
- **ena low.**
  - No fire and no clear.
  - acc, ovf and count hold.
  - The edge detector keeps tracking, so a strobe already high when ena rises does not fire.
- **Reset.** Asynchronous. All registers go to 0: sync registers, acc, ovf, count, valid. Reset mid-operation discards any pending fire.

## Timing
- **Reset values:**
  - `uo_out` = 0.
  - `uio_out` = 0.
  - `uio_oe` = 8'hF0.
- **Latency.** If the pin strobe rises and is sampled at edge N:
  - s_strobe is high after N, and fire is high in cycle N..N+1.
  - acc, count and valid update at edge N+1.
  - The result and valid are visible on the pins after N+1, i.e. 2 clk from the sampling edge.
- **Back-to-back.** Minimum strobe period is 2 cycles: 1 high, 1 low. A strobe held high fires exactly once.
- **Clear latency.** Pin clear sampled at edge N gives zeroed outputs after N+1.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Structure
- **Package `tt_accum_pkg`:**
  - Mode constants MODE_LOAD_SUM / MODE_LOAD_DIFF / MODE_ACC_ADD / MODE_ACC_SUB (2-bit).
  - `uio` bit-index constants: STROBE, CLEAR, MODE_LO, OVF, VALID, CNT_LO.
  - UIO_OE_MASK = 8'hF0.
- **Sub-module `tt_in_sync`:** input registers plus the rising-edge detector. Outputs are the s_* bus and the strobe edge.
- **Top level:** arithmetic, saturation, the status registers and the output packing, all in one always block plus one comb block.

## Test plan
- **Reset/idle.** Assert rst_n low mid-run, then release. Outputs must read `uo_out`=0, `uio_out`=0 and `uio_oe`=F0, and must hold with no strobe.
- **LOAD_SUM, default params.** A=9, B=7, mode 0, strobe pulse. Expect `uo_out`=16 and valid high exactly 1 cycle, 2 clk after the sampling edge; count=1.
- **ACC_ADD saturation (SAT=1, ACCW=8).**
  - 17 strobes of A=15, B=0 saturate: 17×15 = 255 reached exactly, so no overflow yet.
  - One more strobe gives acc=255 and ovf=1.
  - count has wrapped to 2 after 18 fires.
- **Wrap and underflow (SAT=0, ACCW=5).**
  - LOAD_DIFF with A=2, B=5 gives acc=29 and ovf=1.
  - A following clear gives acc=0, ovf=0, count=0.
- **Simultaneous clear + strobe.** With acc=12, raise both in the same cycle. Expect acc=0, no valid pulse, and no later fire.
- **ena gating.**
  - Strobe pulses while ena=0 leave acc/count unchanged.
  - Raising ena while strobe is held high causes no fire; the next fresh edge fires.
